serial_addsub: RTL and testbench

Parametrised bit-serial adder/subtractor: the multi-bit, mode-selectable successor of the combinational half adder/subtractor.
- Accepts two WIDTH-bit operands and a mode bit via a start pulse.
- Processes one bit per clock, LSB first, holding carry/borrow in a flip-flop.
- Returns the result, carry-out/borrow-out and signed overflow with a one-cycle done pulse.
- Serves area-constrained datapaths where one bit-cell is time-shared across the word.

---
 rtl/addsub_pkg.sv | 21 ++
 rtl/serial_addsub_if.sv | 25 ++
 rtl/addsub_bit_cell.sv | 23 ++
 rtl/serial_addsub.sv | 111 +++++++++++
 tb/tb_serial_addsub.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor family:
// operation mode codes, controller states and the signed-overflow rule.
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Overflow from the operand sign bits and the result sign bit.
  function automatic logic signed_ovf(input logic mode, input logic a_msb,
                                      input logic b_msb, input logic s_msb);
    if (mode == MODE_SUB) return (a_msb != b_msb) && (s_msb != a_msb);
    else                  return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Request/response bundle of the bit-serial adder/subtractor.
interface serial_addsub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, mode, a, b,
    input  ready, busy, done, result, cout, ovf
  );

  modport slave (
    input  start, mode, a, b,
    output ready, busy, done, result, cout, ovf
  );
endinterface

// File: rtl/addsub_bit_cell.sv
// One-bit full adder / full subtractor; carry-out doubles as borrow-out in
// subtract mode.
module addsub_bit_cell
  import addsub_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic c,
  input  logic mode,
  output logic s,
  output logic c_out
);

  logic d;

  always_comb begin
    d = x ^ y;
    s = d ^ c;
    if (mode == MODE_SUB) c_out = (~x & y) | (~d & c);
    else                  c_out = (x & y) | (c & d);
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through a
// single shared bit cell; result, carry/borrow and overflow held until the next op.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  serial_addsub_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             s;
  logic             c_out;

  addsub_bit_cell u_cell (
    .x     (a_q[cnt_q]),
    .y     (b_q[cnt_q]),
    .c     (carry_q),
    .mode  (mode_q),
    .s     (s),
    .c_out (c_out)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    mode_d   = mode_q;
    a_d      = a_q;
    b_d      = b_q;
    sr_d     = sr_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          mode_d  = bus.mode;
          carry_d = 1'b0;
          cnt_d   = '0;
          sr_d    = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sr_d[cnt_q] = s;
        carry_d     = c_out;
        cnt_d       = cnt_q + 1'b1;
        // Final bit: publish the word including the MSB written this cycle.
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d = sr_d;
          cout_d   = c_out;
          ovf_d    = signed_ovf(mode_q, a_q[WIDTH-1], b_q[WIDTH-1], s);
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      mode_q   <= MODE_ADD;
      a_q      <= '0;
      b_q      <= '0;
      sr_q     <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sr_q     <= sr_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.ready  = (state_q != ST_RUN);
  assign bus.busy   = (state_q == ST_RUN);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Randomised and directed bench for serial_addsub at WIDTH=2, 8 and 16,
// checked against an arithmetic reference model.
module tb_serial_addsub;

  logic        clk;
  logic        rst;
  logic        st2, st8, st16;
  logic        mode_drv;
  logic [63:0] a_drv, b_drv;
  int unsigned cyc;
  int          passed;
  int          total;

  serial_addsub_if #(.WIDTH(2))  if2 ();
  serial_addsub_if #(.WIDTH(8))  if8 ();
  serial_addsub_if #(.WIDTH(16)) if16 ();

  assign if2.start  = st2;
  assign if2.mode   = mode_drv;
  assign if2.a      = a_drv[1:0];
  assign if2.b      = b_drv[1:0];
  assign if8.start  = st8;
  assign if8.mode   = mode_drv;
  assign if8.a      = a_drv[7:0];
  assign if8.b      = b_drv[7:0];
  assign if16.start = st16;
  assign if16.mode  = mode_drv;
  assign if16.a     = a_drv[15:0];
  assign if16.b     = b_drv[15:0];

  serial_addsub #(.WIDTH(2))  dut2  (.clk(clk), .rst(rst), .bus(if2.slave));
  serial_addsub #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
  serial_addsub #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                input logic m, output logic [63:0] r, output logic co,
                                output logic ov);
    logic [63:0] mask;
    longint      lim, sa, sb, rs;
    mask = (64'd1 << w) - 64'd1;
    lim  = longint'(1) << (w - 1);
    sa   = a[w-1] ? longint'(a) - (lim << 1) : longint'(a);
    sb   = b[w-1] ? longint'(b) - (lim << 1) : longint'(b);
    if (m) begin
      r  = (a - b) & mask;
      co = (a < b);
      rs = sa - sb;
    end else begin
      r  = (a + b) & mask;
      co = (((a + b) >> w) != 64'd0);
      rs = sa + sb;
    end
    ov = (rs >= lim) || (rs < -lim);
  endfunction

  function automatic logic done_of(input int w);
    case (w)
      2:       return if2.done;
      16:      return if16.done;
      default: return if8.done;
    endcase
  endfunction

  function automatic logic [65:0] out_of(input int w);
    case (w)
      2:       return {62'd0, if2.result, if2.cout, if2.ovf};
      16:      return {48'd0, if16.result, if16.cout, if16.ovf};
      default: return {56'd0, if8.result, if8.cout, if8.ovf};
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      2:       st2 = v;
      16:      st16 = v;
      default: st8 = v;
    endcase
  endtask

  // Issues one op from a ready state; returns outputs and edges from accept to done.
  task automatic run_op(input int w, input logic [63:0] a, input logic [63:0] b, input logic m,
                        output logic [63:0] r, output logic co, output logic ov, output int lat);
    logic [65:0] o;
    a_drv = a; b_drv = b; mode_drv = m;
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    lat = 0;
    while (!done_of(w) && lat < 80) begin
      @(posedge clk); #1;
      lat++;
    end
    o  = out_of(w);
    r  = o[65:2];
    co = o[1];
    ov = o[0];
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({if8.ready, if8.busy, if8.done, if8.cout, if8.ovf} !== 5'b10000)
      $display("FAIL reset_flags8: got %b expected 10000",
               {if8.ready, if8.busy, if8.done, if8.cout, if8.ovf});
    else passed++;
    total++;
    if (if8.result !== 8'h00) $display("FAIL reset_result8: got %h expected 00", if8.result);
    else passed++;
    total++;
    if ({if2.ready, if2.busy, if2.done, if2.result} !== 5'b10000)
      $display("FAIL reset_w2: got %b expected 10000", {if2.ready, if2.busy, if2.done, if2.result});
    else passed++;
    total++;
    if ({if16.ready, if16.busy, if16.done, if16.result} !== 19'h40000)
      $display("FAIL reset_w16: got %h expected 40000",
               {if16.ready, if16.busy, if16.done, if16.result});
    else passed++;
  endtask

  task automatic test_directed;
    logic [26:0] tbl [5];
    logic [63:0] r;
    logic        co, ov;
    int          lat;
    tbl[0] = {8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0};
    tbl[1] = {8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = {8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = {8'h05, 8'h07, 1'b1, 8'hFE, 1'b1, 1'b0};
    tbl[4] = {8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      run_op(8, {56'd0, tbl[i][26:19]}, {56'd0, tbl[i][18:11]}, tbl[i][10], r, co, ov, lat);
      total++;
      if ({r[7:0], co, ov} !== tbl[i][9:0])
        $display("FAIL directed%0d: got res=%h cout=%b ovf=%b expected res=%h cout=%b ovf=%b",
                 i, r[7:0], co, ov, tbl[i][9:2], tbl[i][1], tbl[i][0]);
      else passed++;
      total++;
      if (lat !== 8) $display("FAIL latency%0d: got %0d expected 8", i, lat);
      else passed++;
    end
  endtask

  task automatic test_random;
    int          widths [3];
    logic [63:0] mask, a, b, r, er;
    logic        m, co, ov, eco, eov;
    int          lat;
    widths[0] = 2; widths[1] = 8; widths[2] = 16;
    for (int wi = 0; wi < 3; wi++) begin
      mask = (64'd1 << widths[wi]) - 64'd1;
      for (int n = 0; n < 16; n++) begin
        a = {$urandom(), $urandom()} & mask;
        b = {$urandom(), $urandom()} & mask;
        m = 1'($urandom_range(0, 1));
        if (n == 0) begin a = mask; b = mask; end
        if (n == 1) begin a = 64'd0; b = mask; m = 1'b1; end
        if (n == 2) begin a = mask >> 1; b = 64'd1; m = 1'b0; end
        model(widths[wi], a, b, m, er, eco, eov);
        run_op(widths[wi], a, b, m, r, co, ov, lat);
        total++;
        if ({r, co, ov} !== {er, eco, eov})
          $display("FAIL random_w%0d: a=%h b=%h mode=%b got res=%h cout=%b ovf=%b expected res=%h cout=%b ovf=%b",
                   widths[wi], a, b, m, r, co, ov, er, eco, eov);
        else passed++;
        total++;
        if (lat !== widths[wi])
          $display("FAIL latency_w%0d: got %0d expected %0d", widths[wi], lat, widths[wi]);
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] r;
    logic        co, ov;
    int          lat, k;
    int unsigned c1, c2;
    run_op(8, 64'h10, 64'h20, 1'b0, r, co, ov, lat);
    c1 = cyc;
    total++;
    if ({r[7:0], co, ov} !== {8'h30, 1'b0, 1'b0})
      $display("FAIL b2b_op1: got res=%h cout=%b ovf=%b expected 30/0/0", r[7:0], co, ov);
    else passed++;
    a_drv = 64'h10; b_drv = 64'h20; mode_drv = 1'b1;
    st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    total++;
    if ({if8.busy, if8.done} !== 2'b10)
      $display("FAIL b2b_accept: got busy/done=%b expected 10", {if8.busy, if8.done});
    else passed++;
    k = 0;
    while (!if8.done && k < 40) begin @(posedge clk); #1; k++; end
    c2 = cyc;
    total++;
    if (c2 - c1 !== 9) $display("FAIL b2b_spacing: got %0d expected 9", c2 - c1);
    else passed++;
    total++;
    if ({if8.result, if8.cout, if8.ovf} !== {8'hF0, 1'b1, 1'b0})
      $display("FAIL b2b_op2: got res=%h cout=%b ovf=%b expected F0/1/0",
               if8.result, if8.cout, if8.ovf);
    else passed++;
  endtask

  task automatic test_ignored;
    int          ndone;
    logic [9:0]  seen;
    @(posedge clk); #1;
    a_drv = 64'h12; b_drv = 64'h34; mode_drv = 1'b0;
    st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    a_drv = 64'hAA; b_drv = 64'h55; mode_drv = 1'b1;
    st8 = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    st8 = 1'b0;
    a_drv = 64'h3C; b_drv = 64'hC3;
    ndone = 0;
    seen  = '0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (if8.done) begin
        ndone++;
        seen = {if8.result, if8.cout, if8.ovf};
      end
    end
    total++;
    if (ndone !== 1) $display("FAIL ignored_done_count: got %0d expected 1", ndone);
    else passed++;
    total++;
    if (seen !== {8'h46, 1'b0, 1'b0})
      $display("FAIL ignored_result: got %h expected %h", seen, {8'h46, 1'b0, 1'b0});
    else passed++;
  endtask

  task automatic test_reset_mid;
    logic [63:0] r;
    logic        co, ov;
    int          lat, ndone;
    run_op(8, 64'h7F, 64'h01, 1'b0, r, co, ov, lat);
    a_drv = 64'h55; b_drv = 64'h22; mode_drv = 1'b0;
    st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({if8.ready, if8.busy, if8.done, if8.result, if8.cout, if8.ovf} !== 13'h1000)
      $display("FAIL reset_mid_outputs: got %h expected 1000",
               {if8.ready, if8.busy, if8.done, if8.result, if8.cout, if8.ovf});
    else passed++;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (if8.done) ndone++;
    end
    total++;
    if (ndone !== 0) $display("FAIL reset_mid_no_done: got %0d expected 0", ndone);
    else passed++;
    run_op(8, 64'h55, 64'h22, 1'b0, r, co, ov, lat);
    total++;
    if ({r[7:0], co, ov, lat} !== {8'h77, 1'b0, 1'b0, 32'd8})
      $display("FAIL reset_mid_fresh: got res=%h cout=%b ovf=%b lat=%0d expected 77/0/0/8",
               r[7:0], co, ov, lat);
    else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    passed = 0;
    total  = 0;
    rst = 1'b1;
    st2 = 1'b0; st8 = 1'b0; st16 = 1'b0;
    mode_drv = 1'b0;
    a_drv = '0; b_drv = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
